// File: rtl/hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// hazard_ctrl_if
//
// Bundles the signals exchanged between the pipeline datapath and the hazard
// and control unit. Signal suffixes are written from the hazard unit's point
// of view: *_i are observed by the unit, *_o are driven by it.
//
// Modports:
//   slave  - hazard unit side (observes operand/status, drives stall/flush)
//   master - pipeline side (drives operand/status, observes stall/flush)
//
// Signals:
//   id_rs1_addr_i / id_rs2_addr_i  [4:0]  source registers of the ID instruction
//   id_rs1_used_i / id_rs2_used_i         ID instruction really reads rs1/rs2
//   ex_rd_i                        [4:0]  destination register of the EX instruction
//   ex_memread_en_i                       EX instruction is a load
//   ex_redirect_i                         taken branch/jump resolved in EX
//   mem_req_i                             MEM stage holds a load/store
//   mem_ready_i                           data memory completes the access
//   pc_stall_o                            hold PC
//   if_id_stall_o / if_id_flush_o         IF/ID register control
//   id_ex_stall_o / id_ex_flush_o         ID/EX register control
//   ex_mem_stall_o                        hold EX/MEM
// ----------------------------------------------------------------------------
interface hazard_ctrl_if;

    logic [4:0] id_rs1_addr_i;
    logic [4:0] id_rs2_addr_i;
    logic       id_rs1_used_i;
    logic       id_rs2_used_i;
    logic [4:0] ex_rd_i;
    logic       ex_memread_en_i;
    logic       ex_redirect_i;
    logic       mem_req_i;
    logic       mem_ready_i;

    logic       pc_stall_o;
    logic       if_id_stall_o;
    logic       if_id_flush_o;
    logic       id_ex_stall_o;
    logic       id_ex_flush_o;
    logic       ex_mem_stall_o;

    modport slave (
        input  id_rs1_addr_i,
        input  id_rs2_addr_i,
        input  id_rs1_used_i,
        input  id_rs2_used_i,
        input  ex_rd_i,
        input  ex_memread_en_i,
        input  ex_redirect_i,
        input  mem_req_i,
        input  mem_ready_i,
        output pc_stall_o,
        output if_id_stall_o,
        output if_id_flush_o,
        output id_ex_stall_o,
        output id_ex_flush_o,
        output ex_mem_stall_o
    );

    modport master (
        output id_rs1_addr_i,
        output id_rs2_addr_i,
        output id_rs1_used_i,
        output id_rs2_used_i,
        output ex_rd_i,
        output ex_memread_en_i,
        output ex_redirect_i,
        output mem_req_i,
        output mem_ready_i,
        input  pc_stall_o,
        input  if_id_stall_o,
        input  if_id_flush_o,
        input  id_ex_stall_o,
        input  id_ex_flush_o,
        input  ex_mem_stall_o
    );

endinterface : hazard_ctrl_if

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard and control unit for the five-stage core. Detects load-use hazards
// and data-memory waits, handles EX-stage redirects, and drives the stall and
// flush controls of the PC and the IF/ID, ID/EX and EX/MEM stage registers.
// A three-state FSM (RUN / MEM_WAIT / SQUASH) sequences multi-cycle memory
// waits and the one-cycle squash of the fetch word that is already in flight
// from the synchronous instruction memory when a redirect happens.
//
// Ports:
//   clk_i        core clock, rising edge
//   n_rst        asynchronous active-low reset
//   hz_if        hazard_ctrl_if.slave - operand/status inputs, stall/flush outputs
//   stall_cnt_o  [31:0] cycles with pc_stall_o high      (HAZARD_PERF_CNT_EN only)
//   flush_cnt_o  [31:0] cycles with if_id_flush_o high   (HAZARD_PERF_CNT_EN only)
//
// Configuration:
//   HAZARD_PERF_CNT_EN - when defined, adds the two wrapping 32-bit
//                        performance counters and their output ports.
//
// Priority of events in any cycle: memory wait > redirect > (owed squash) >
// load-use. All stall/flush outputs are combinational from state and inputs.
// ----------------------------------------------------------------------------
module hazard_ctrl (
    input  logic         clk_i,
    input  logic         n_rst,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]  stall_cnt_o,
    output logic [31:0]  flush_cnt_o,
`endif
    hazard_ctrl_if.slave hz_if
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_SQUASH   = 2'd2
    } state_e;

    // One bit per stage-register control line, kept together so the decode
    // below can assign a whole control pattern at once.
    typedef struct packed {
        logic pc_stall;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_stall;
        logic id_ex_flush;
        logic ex_mem_stall;
    } ctl_t;

    localparam ctl_t CTL_STALL_ALL = '{pc_stall: 1'b1, if_id_stall: 1'b1, if_id_flush: 1'b0,
                                       id_ex_stall: 1'b1, id_ex_flush: 1'b0, ex_mem_stall: 1'b1};
    localparam ctl_t CTL_REDIRECT  = '{pc_stall: 1'b0, if_id_stall: 1'b0, if_id_flush: 1'b1,
                                       id_ex_stall: 1'b0, id_ex_flush: 1'b1, ex_mem_stall: 1'b0};
    localparam ctl_t CTL_SQUASH    = '{pc_stall: 1'b0, if_id_stall: 1'b0, if_id_flush: 1'b1,
                                       id_ex_stall: 1'b0, id_ex_flush: 1'b0, ex_mem_stall: 1'b0};
    localparam ctl_t CTL_BUBBLE    = '{pc_stall: 1'b1, if_id_stall: 1'b1, if_id_flush: 1'b0,
                                       id_ex_stall: 1'b0, id_ex_flush: 1'b1, ex_mem_stall: 1'b0};

    state_e state_q, state_d;
    logic   pend_squash_q, pend_squash_d;   // squash owed when MEM_WAIT ends
    ctl_t   ctl;                            // ungated control decision
    ctl_t   ctl_out;                        // control after reset gating

    logic   load_use;
    logic   mem_wait;
    logic   rs1_hit;
    logic   rs2_hit;
    logic   take_run;                       // evaluate the RUN rules this cycle
    logic   take_squash;                    // evaluate the squash rules this cycle

    // ------------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------------
    // A load into x0 never produces a value worth waiting for.
    assign rs1_hit  = hz_if.id_rs1_used_i && (hz_if.id_rs1_addr_i == hz_if.ex_rd_i);
    assign rs2_hit  = hz_if.id_rs2_used_i && (hz_if.id_rs2_addr_i == hz_if.ex_rd_i);
    assign load_use = hz_if.ex_memread_en_i && (hz_if.ex_rd_i != 5'd0) && (rs1_hit || rs2_hit);
    assign mem_wait = hz_if.mem_req_i && !hz_if.mem_ready_i;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk_i or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= ST_RUN;
            pend_squash_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_squash_q <= pend_squash_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------------
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d       = state_q;
        pend_squash_d = pend_squash_q;
        ctl           = '0;
        take_run      = 1'b0;
        take_squash   = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                take_run = 1'b1;
            end

            // EX (and with it ex_redirect_i) is frozen while we wait, so a
            // redirect seen during the wait is simply acted on at exit.
            ST_MEM_WAIT: begin
                if (mem_wait) begin
                    ctl = CTL_STALL_ALL;
                end else if (pend_squash_q) begin
                    take_squash = 1'b1;
                end else begin
                    take_run = 1'b1;
                end
            end

            // The squash is deferred when memory stalls the pipe; the fetch
            // word in flight is held in place, so it is still discarded later.
            ST_SQUASH: begin
                if (mem_wait) begin
                    ctl           = CTL_STALL_ALL;
                    state_d       = ST_MEM_WAIT;
                    pend_squash_d = 1'b1;
                end else begin
                    take_squash = 1'b1;
                end
            end

            default: begin
                state_d       = ST_RUN;
                pend_squash_d = 1'b0;
            end
        endcase

        if (take_run) begin
            pend_squash_d = 1'b0;
            if (mem_wait) begin
                ctl     = CTL_STALL_ALL;
                state_d = ST_MEM_WAIT;
            end else if (hz_if.ex_redirect_i) begin
                // Any load-use on the ID instruction is moot: it is squashed.
                ctl     = CTL_REDIRECT;
                state_d = ST_SQUASH;
            end else if (load_use) begin
                ctl     = CTL_BUBBLE;
                state_d = ST_RUN;
            end else begin
                state_d = ST_RUN;
            end
        end

        // The ID slot holds the bubble inserted by the redirect, so load-use
        // is not considered during the squash cycle. A new redirect restarts
        // the squash sequence.
        if (take_squash) begin
            pend_squash_d = 1'b0;
            if (hz_if.ex_redirect_i) begin
                ctl     = CTL_REDIRECT;
                state_d = ST_SQUASH;
            end else begin
                ctl     = CTL_SQUASH;
                state_d = ST_RUN;
            end
        end
    end

    // NOTE: the combinational hazard paths are gated by n_rst so the pipeline
    // sees no stall or flush while reset is asserted.
    assign ctl_out = n_rst ? ctl : '0;

    assign hz_if.pc_stall_o     = ctl_out.pc_stall;
    assign hz_if.if_id_stall_o  = ctl_out.if_id_stall;
    assign hz_if.if_id_flush_o  = ctl_out.if_id_flush;
    assign hz_if.id_ex_stall_o  = ctl_out.id_ex_stall;
    assign hz_if.id_ex_flush_o  = ctl_out.id_ex_flush;
    assign hz_if.ex_mem_stall_o = ctl_out.ex_mem_stall;

    // ------------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Both counters wrap naturally at 2^32.
    always_ff @(posedge clk_i or negedge n_rst) begin
        if (!n_rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if (ctl_out.pc_stall) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (ctl_out.if_id_flush) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl. The reference model tracks only one
// piece of history, "a fetch squash is still owed", and derives each cycle's
// controls from the event priority memory wait > redirect > owed squash >
// load-use. Directed steps follow the test plan, then a randomized run.
// Output vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
// id_ex_flush, ex_mem_stall}.
// ----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam logic [5:0] V_NONE   = 6'b000000;
    localparam logic [5:0] V_STALL  = 6'b110101;
    localparam logic [5:0] V_REDIR  = 6'b001010;
    localparam logic [5:0] V_SQUASH = 6'b001000;
    localparam logic [5:0] V_BUBBLE = 6'b110010;

    logic clk_i = 1'b0;
    logic n_rst = 1'b0;

    int checks   = 0;
    int failures = 0;

    // Model state: a squash of the in-flight fetch word is still owed.
    bit m_squash_owed = 1'b0;

    hazard_ctrl_if hif ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] m_stall_cnt = 32'd0;
    logic [31:0] m_flush_cnt = 32'd0;
`endif

    hazard_ctrl dut (
        .clk_i       (clk_i),
        .n_rst       (n_rst),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cnt_o (stall_cnt),
        .flush_cnt_o (flush_cnt),
`endif
        .hz_if       (hif)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [5:0] dut_out();
        return {hif.pc_stall_o, hif.if_id_stall_o, hif.if_id_flush_o,
                hif.id_ex_stall_o, hif.id_ex_flush_o, hif.ex_mem_stall_o};
    endfunction

    function automatic bit model_mw();
        return hif.mem_req_i && !hif.mem_ready_i;
    endfunction

    function automatic bit model_lu();
        bit hit1, hit2;
        hit1 = hif.id_rs1_used_i && (hif.id_rs1_addr_i == hif.ex_rd_i);
        hit2 = hif.id_rs2_used_i && (hif.id_rs2_addr_i == hif.ex_rd_i);
        return hif.ex_memread_en_i && (hif.ex_rd_i != 5'd0) && (hit1 || hit2);
    endfunction

    function automatic logic [5:0] model_out();
        if (!n_rst)            return V_NONE;
        if (model_mw())        return V_STALL;
        if (hif.ex_redirect_i) return V_REDIR;
        if (m_squash_owed)     return V_SQUASH;
        if (model_lu())        return V_BUBBLE;
        return V_NONE;
    endfunction

    // Advance the model at the clock edge; a memory wait freezes everything.
    task automatic model_update(input logic [5:0] exp);
        if (!n_rst) begin
            m_squash_owed = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
            m_stall_cnt = 32'd0;
            m_flush_cnt = 32'd0;
`endif
        end else begin
            if (!model_mw()) m_squash_owed = hif.ex_redirect_i;
`ifdef HAZARD_PERF_CNT_EN
            if (exp[5]) m_stall_cnt = m_stall_cnt + 32'd1;
            if (exp[3]) m_flush_cnt = m_flush_cnt + 32'd1;
`endif
        end
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic memrd, input logic redir,
                         input logic req, input logic rdy);
        hif.id_rs1_addr_i   = rs1;
        hif.id_rs2_addr_i   = rs2;
        hif.id_rs1_used_i   = u1;
        hif.id_rs2_used_i   = u2;
        hif.ex_rd_i         = rd;
        hif.ex_memread_en_i = memrd;
        hif.ex_redirect_i   = redir;
        hif.mem_req_i       = req;
        hif.mem_ready_i     = rdy;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic assert_reset();
        n_rst = 1'b0;
        m_squash_owed = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
        m_stall_cnt = 32'd0;
        m_flush_cnt = 32'd0;
`endif
    endtask

    // One clock cycle: check at the falling edge, advance model at the rising
    // edge, return 1 time unit after it so the caller can change inputs.
    task automatic tick(input string tag, input bit use_want, input logic [5:0] want);
        logic [5:0] exp;
        logic [5:0] obs;
        @(negedge clk_i);
        exp = model_out();
        obs = dut_out();
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: outputs observed=%b expected=%b", tag, obs, exp);
        end
        if (use_want) begin
            checks++;
            assert (obs === want) else begin
                failures++;
                $error("FAIL %s_plan: outputs observed=%b expected=%b", tag, obs, want);
            end
        end
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        assert (stall_cnt === m_stall_cnt) else begin
            failures++;
            $error("FAIL %s_stall_cnt: observed=%0d expected=%0d", tag, stall_cnt, m_stall_cnt);
        end
        checks++;
        assert (flush_cnt === m_flush_cnt) else begin
            failures++;
            $error("FAIL %s_flush_cnt: observed=%0d expected=%0d", tag, flush_cnt, m_flush_cnt);
        end
`endif
        @(posedge clk_i);
        model_update(exp);
        #1;
    endtask

    initial begin
        // Reset, including gating of live LU/MW inputs.
        idle();
        assert_reset();
        tick("reset_idle", 1'b1, V_NONE);
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        tick("reset_gated", 1'b1, V_NONE);
        idle();
        n_rst = 1'b1;
        tick("after_reset", 1'b1, V_NONE);

        // Load-use: exactly one bubble, and none for x0.
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick("lu_bubble", 1'b1, V_BUBBLE);
        idle();
        tick("lu_done", 1'b1, V_NONE);
        drive(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick("lu_x0", 1'b1, V_NONE);
        drive(5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        tick("lu_rs2", 1'b1, V_BUBBLE);
        drive(5'd9, 5'd3, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        tick("lu_unused_rs1", 1'b1, V_NONE);

        // Redirect: two flushed slots, then quiet.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick("redir_n", 1'b1, V_REDIR);
        idle();
        tick("redir_n1", 1'b1, V_SQUASH);
        tick("redir_n2", 1'b1, V_NONE);

        // Memory wait of 3 cycles, released in the ready cycle.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick("mw_1", 1'b1, V_STALL);
        tick("mw_2", 1'b1, V_STALL);
        tick("mw_3", 1'b1, V_STALL);
        hif.mem_ready_i = 1'b1;
        tick("mw_ready", 1'b1, V_NONE);
        idle();
        tick("mw_after", 1'b1, V_NONE);

        // MW + redirect + LU together: stalls, then redirect at exit, then squash.
        drive(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        tick("sim_stall_1", 1'b1, V_STALL);
        tick("sim_stall_2", 1'b1, V_STALL);
        hif.mem_ready_i = 1'b1;
        tick("sim_exit_redir", 1'b1, V_REDIR);
        hif.ex_redirect_i = 1'b0;
        hif.mem_req_i     = 1'b0;
        tick("sim_squash_no_lu", 1'b1, V_SQUASH);
        idle();
        tick("sim_done", 1'b1, V_NONE);

        // Memory wait during SQUASH defers the squash to the wait exit.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick("pend_redir", 1'b1, V_REDIR);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick("pend_stall_1", 1'b1, V_STALL);
        tick("pend_stall_2", 1'b1, V_STALL);
        hif.mem_ready_i = 1'b1;
        tick("pend_exit_squash", 1'b1, V_SQUASH);
        idle();
        tick("pend_done", 1'b1, V_NONE);

        // Redirect arriving with a squash pending restarts the squash.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick("restart_redir", 1'b1, V_REDIR);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick("restart_stall", 1'b1, V_STALL);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick("restart_redir2", 1'b1, V_REDIR);
        idle();
        tick("restart_squash", 1'b1, V_SQUASH);
        tick("restart_done", 1'b1, V_NONE);

        // Reset in the middle of a 5-cycle memory wait.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick("rstmw_1", 1'b1, V_STALL);
        tick("rstmw_2", 1'b1, V_STALL);
        assert_reset();
        tick("rstmw_in_reset", 1'b1, V_NONE);
        n_rst = 1'b1;
`ifdef HAZARD_PERF_CNT_EN
        checks++;
        assert (stall_cnt === 32'd0 && flush_cnt === 32'd0) else begin
            failures++;
            $error("FAIL rstmw_counters: observed=%0d/%0d expected=0/0", stall_cnt, flush_cnt);
        end
`endif
        tick("rstmw_4", 1'b1, V_STALL);
        tick("rstmw_5", 1'b1, V_STALL);
        hif.mem_ready_i = 1'b1;
        tick("rstmw_ready", 1'b1, V_NONE);

        // Reset while a squash is pending clears the pending bit.
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick("rstpend_redir", 1'b1, V_REDIR);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick("rstpend_stall", 1'b1, V_STALL);
        assert_reset();
        tick("rstpend_in_reset", 1'b1, V_NONE);
        n_rst = 1'b1;
        hif.mem_ready_i = 1'b1;
        tick("rstpend_no_squash", 1'b1, V_NONE);
        idle();

`ifdef HAZARD_PERF_CNT_EN
        // Counter scenario: 1 load-use, 1 redirect, a 3-cycle wait.
        assert_reset();
        tick("cnt_reset", 1'b1, V_NONE);
        n_rst = 1'b1;
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick("cnt_lu", 1'b1, V_BUBBLE);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick("cnt_redir", 1'b1, V_REDIR);
        idle();
        tick("cnt_squash", 1'b1, V_SQUASH);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick("cnt_mw", 1'b1, V_STALL);
        hif.mem_ready_i = 1'b1;
        tick("cnt_ready", 1'b1, V_NONE);
        idle();
        checks++;
        assert (stall_cnt === 32'd4) else begin
            failures++;
            $error("FAIL cnt_stall_total: observed=%0d expected=4", stall_cnt);
        end
        checks++;
        assert (flush_cnt === 32'd2) else begin
            failures++;
            $error("FAIL cnt_flush_total: observed=%0d expected=2", flush_cnt);
        end
`endif

        // Randomized run with small register ranges to provoke collisions.
        for (int i = 0; i < 600; i++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)));
            if ($urandom_range(0, 79) == 0) assert_reset();
            tick("random", 1'b0, V_NONE);
            n_rst = 1'b1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_hazard_ctrl

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and control unit for the five-stage core. It watches decode operands, execute-stage load/redirect status and the data-memory handshake, and it drives the stall and flush inputs of the PC register and of the IF/ID, ID/EX and EX/MEM stage registers. A small FSM sequences multi-cycle memory waits and the post-redirect fetch squash. Optional performance counters report lost cycles.

## Interface
- No parameters.
- clk_i  in  1  core clock, rising edge
- n_rst  in  1  reset, asynchronous, active-low
- id_rs1_addr_i / id_rs2_addr_i  in  5 each  source registers of the instruction in ID
- id_rs1_used_i / id_rs2_used_i  in  1 each  ID instruction actually reads rs1/rs2
- ex_rd_i  in  5  destination register of the instruction in EX
- ex_memread_en_i  in  1  EX instruction is a load
- ex_redirect_i  in  1  taken branch or jump resolved in EX this cycle
- mem_req_i  in  1  MEM stage holds a load/store
- mem_ready_i  in  1  data memory completes the MEM access this cycle
- pc_stall_o  out  1  hold PC
- if_id_stall_o / if_id_flush_o  out  1 each  IF/ID control
- id_ex_stall_o / id_ex_flush_o  out  1 each  ID/EX control (the register gives flush priority over stall)
- ex_mem_stall_o  out  1  hold EX/MEM
- stall_cnt_o / flush_cnt_o  out  32 each  perf counters (only with HAZARD_PERF_CNT_EN)

## Operation
- FSM states: RUN, MEM_WAIT, SQUASH. Reset state is RUN.
- Load-use hazard (LU): ex_memread_en_i && ex_rd_i != 0 && ((id_rs1_used_i && id_rs1_addr_i == ex_rd_i) || (id_rs2_used_i && id_rs2_addr_i == ex_rd_i)).
- Memory wait (MW): mem_req_i && !mem_ready_i.
- Outputs are combinational from the state and the inputs. The priority order is MW > redirect > LU.
- RUN:
  - MW: assert pc_stall, if_id_stall, id_ex_stall and ex_mem_stall; assert no flush; next state is MEM_WAIT.
  - Otherwise, if ex_redirect_i: assert if_id_flush and id_ex_flush; assert no stall; next state is SQUASH. A simultaneous LU is ignored, because the ID instruction is squashed.
  - Otherwise, if LU: assert pc_stall and if_id_stall, and id_ex_flush (inserts a bubble); stay in RUN.
  - Otherwise: all outputs are 0.
- MEM_WAIT:
  - All four stall outputs are asserted while MW holds; no flush.
  - When mem_ready_i is seen, all stalls deassert in that same cycle, and the RUN rules are evaluated on the current inputs.
  - ex_redirect_i is frozen together with EX, so it is acted on at exit.
- SQUASH: assert if_id_flush for exactly one cycle. This discards the fetch word already in flight from the synchronous instruction memory.
  - If MW occurs in SQUASH: stall all stages and go to MEM_WAIT. The squash is then taken on exit; MEM_WAIT records a pending-squash bit.
  - Otherwise: return to RUN.
- A redirect that arrives while the pending-squash bit is set restarts SQUASH.
- LU compares against x0 never stall.

## Timing
- Combinational paths:
  - LU to stall/flush: same cycle.
  - ex_redirect_i to flush: same cycle.
  - mem_ready_i to stall release: same cycle.
- State updates on the rising edge of clk_i.
- Load-use costs exactly 1 bubble cycle.
- A redirect costs 2 flushed slots: cycle N flushes IF/ID and ID/EX; cycle N+1 flushes IF/ID only.
- A memory wait of k cycles with mem_ready_i low gives k fully stalled cycles. The stall also covers the cycle of the initial request if mem_ready_i is low.
- Reset (asynchronous, at any time, including mid-MEM_WAIT or mid-SQUASH):
  - State goes to RUN; the pending-squash bit is cleared; the counters go to 0.
  - All outputs are 0 while n_rst is low, except for any combinational LU/MW effects, which are gated off during reset.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt_o increments once per cycle in which pc_stall_o is high.
  - flush_cnt_o increments once per cycle in which if_id_flush_o is high.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and reset to 0.
- HAZARD_PERF_CNT_EN undefined: the counter ports and logic are absent. All other behaviour is identical.

## Test plan
- Load-use: ex_memread_en_i=1, ex_rd_i=5, id_rs1_addr_i=5, id_rs1_used_i=1.
  - Expect pc_stall=if_id_stall=id_ex_flush=1 for exactly 1 cycle.
  - Repeat with ex_rd_i=0; expect no stall.
- Redirect: ex_redirect_i=1 for 1 cycle at cycle N.
  - Expect if_id_flush=id_ex_flush=1 at N, and if_id_flush=1 only at N+1.
  - Expect all outputs 0 at N+2.
- Memory wait: mem_req_i=1, mem_ready_i low for 3 cycles, then high.
  - Expect all 4 stalls high for 3 cycles and low in the ready cycle.
  - Expect no flush at any point.
- Simultaneous events:
  - MW + redirect + LU in one cycle: stalls only.
  - After ready: redirect flush in that cycle, SQUASH in the next cycle, and LU never acted on.
- Reset mid-MEM_WAIT: drop n_rst for 1 cycle during a 5-cycle wait. Expect the state to be RUN, all outputs 0, and counters 0.
- With HAZARD_PERF_CNT_EN: run 1 load-use, 1 redirect and a 3-cycle wait. Expect stall_cnt_o=4 and flush_cnt_o=2.
